miner_csr_array: RTL and testbench
==================================

// Module: miner_csr_array
// PURPOSE
//  Parametrised Avalon-MM slave CSR block fronting NUM_CORES parallel SHA-256 miner cores.
//  Holds block header and target words, and issues start/abort pulses to the cores.
//  Arbitrates and latches the first winning nonce, and keeps sticky W1C status, a cycle
//  counter and a level interrupt. Sits between the HPS/Avalon interconnect and the core array.
// PARAMETERS
//  ADDRW      6   slave word-address width
//  DATAW      32  bus/register width
//  NUM_CORES  4   miner cores (1..16)
//  HDR_WORDS  19  header words excluding nonce (0x20..0x20+HDR_WORDS-1)
//  TGT_WORDS  8   256-bit target words (0x38..0x3F)
// PORTS
//  clk               in  1                clock, all logic rising-edge
//  reset_n           in  1                asynchronous, active-low reset
//  slave_address     in  ADDRW            word address
//  slave_writedata   in  DATAW            write data
//  slave_write       in  1                write strobe, qualified by chipselect
//  slave_read        in  1                read strobe, qualified by chipselect
//  slave_chipselect  in  1                slave select
//  slave_readdata    out DATAW            read data, valid 1 cycle after read strobe
//  irq               out 1                level interrupt
//  core_start        out 1                1-cycle start pulse to all cores
//  core_abort        out 1                1-cycle abort pulse to all cores
//  core_header       out HDR_WORDS*DATAW  header words, word0 in LSBs
//  core_target       out TGT_WORDS*DATAW  target, word0 in LSBs
//  core_nonce_base   out DATAW            starting nonce; core i starts at base+i
//  core_done         in  NUM_CORES        core exhausted its nonce range (level)
//  core_found        in  NUM_CORES        core has valid nonce (level, with core_nonce)
//  core_nonce        in  NUM_CORES*DATAW  per-core winning nonce
// BEHAVIOUR
//  Reset: every register and output is 0; FSM=IDLE. Applies mid-RUN with no pulse.
//  Map: 0 CTRL (RW) b0 start (self-clearing, reads 0), b1 abort (self-clearing), b2 irq_en.
//   1 STATUS: b0 busy (RO), b1 done (W1C), b2 found (W1C).
//   2 NONCE_FOUND (RO). 3 FOUND_CORE (RO, low 4 bits).
//   4 NONCE_BASE (RW). 5 RUN_CYCLES (RO).
//   0x20.. header (RW); 0x38..0x3F target (RW).
//  Unmapped reads return 0; writes to RO/unmapped addresses are ignored.
//  Read: slave_readdata registered from the address on the strobe cycle (latency 1); it holds
//   until the next read. Write and read in the same cycle: write wins, readdata unchanged.
//  FSM IDLE -> RUN on a CTRL write with b0=1; core_start pulses the next cycle.
//   The same write clears done, found, NONCE_FOUND, FOUND_CORE and RUN_CYCLES.
//  RUN -> DONE when any core_found=1 or all core_done=1; sets done, plus found if a find.
//  RUN -> IDLE on CTRL b1=1: core_abort pulses; done and found are unchanged.
//  DONE -> RUN on start exactly as from IDLE; b1 in DONE/IDLE is a no-op (no pulse).
//  In RUN: start writes and header/target/NONCE_BASE writes are ignored; irq_en stays writable.
//  Start and abort both set in one write: abort wins in RUN; start wins otherwise.
//  Found capture: first cycle with any core_found in RUN; lowest index wins ties.
//   That core's nonce goes to NONCE_FOUND and its index to FOUND_CORE.
//   Later finds are ignored until the next start.
//  RUN_CYCLES increments every RUN cycle and saturates at all-ones.
//  W1C write on the same cycle as a hardware set: the set wins.
//  busy = (state==RUN); irq = irq_en & (done | found), registered.
// TESTING
//  Write hdr 0x20..0x32 = i, NONCE_BASE = 0x100, CTRL = 1 -> core_start high exactly 1 cycle;
//   core_header word i = i; STATUS = 0x1.
//  Cores 1 and 3 found in the same cycle (nonces 0xAA, 0xBB) -> NONCE_FOUND = 0xAA,
//   FOUND_CORE = 1, STATUS = 0x6; a later core-0 find leaves them unchanged.
//  All core_done after 50 RUN cycles, no find -> STATUS = 0x2; RUN_CYCLES = 50;
//   with irq_en = 1, irq rises next cycle.
//  Write STATUS = 0x2 while found set -> done clears, found stays; irq drops only after a
//   0x4 W1C.
//  In RUN: write hdr 0x20 = 0xDEAD and CTRL = 0x3 -> header unchanged; core_abort pulses 1 cycle;
//   state IDLE; core_start never pulses.
//  Assert reset_n low mid-RUN asynchronously -> all outputs 0 immediately; the first read
//   after release returns 0 for STATUS.

Source files
------------

// File: rtl/miner_csr_array.sv
// miner_csr_array: Avalon-MM slave CSR block in front of NUM_CORES SHA-256 miner cores.
// Holds the header/target/nonce-base words, pulses start/abort to the cores, latches the
// first winning nonce, and keeps sticky W1C status, a RUN cycle counter and a level irq.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   slave_address/writedata/write/read/chipselect, slave_readdata   Avalon-MM slave
//   irq                             level interrupt, irq_en & (done | found)
//   core_start, core_abort          1-cycle pulses to all cores
//   core_header, core_target        configured words, word0 in LSBs
//   core_nonce_base                 starting nonce (core i starts at base+i)
//   core_done, core_found, core_nonce   per-core status and winning nonce
module miner_csr_array #(
  parameter int unsigned ADDRW     = 6,
  parameter int unsigned DATAW     = 32,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned HDR_WORDS = 19,
  parameter int unsigned TGT_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDRW-1:0]           slave_address,
  input  logic [DATAW-1:0]           slave_writedata,
  input  logic                       slave_write,
  input  logic                       slave_read,
  input  logic                       slave_chipselect,
  output logic [DATAW-1:0]           slave_readdata,
  output logic                       irq,
  output logic                       core_start,
  output logic                       core_abort,
  output logic [HDR_WORDS*DATAW-1:0] core_header,
  output logic [TGT_WORDS*DATAW-1:0] core_target,
  output logic [DATAW-1:0]           core_nonce_base,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*DATAW-1:0] core_nonce
);

  localparam int unsigned A_CTRL     = 0;
  localparam int unsigned A_STATUS   = 1;
  localparam int unsigned A_NONCE    = 2;
  localparam int unsigned A_CORE     = 3;
  localparam int unsigned A_BASE     = 4;
  localparam int unsigned A_CYCLES   = 5;
  localparam int unsigned HDR_BASE   = 32;
  localparam int unsigned TGT_BASE   = 56;
  localparam int unsigned CORE_IDXW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic                   abort_q, abort_d;
  logic                   irq_en_q, irq_en_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic                   irq_q, irq_d;
  logic [DATAW-1:0]       nonce_found_q, nonce_found_d;
  logic [CORE_IDXW-1:0]   found_core_q, found_core_d;
  logic [DATAW-1:0]       nonce_base_q, nonce_base_d;
  logic [DATAW-1:0]       run_cycles_q, run_cycles_d;
  logic [DATAW-1:0]       readdata_q, readdata_d;
  logic [DATAW-1:0]       hdr_q [HDR_WORDS];
  logic [DATAW-1:0]       hdr_d [HDR_WORDS];
  logic [DATAW-1:0]       tgt_q [TGT_WORDS];
  logic [DATAW-1:0]       tgt_d [TGT_WORDS];

  logic [31:0]            addr_u;
  logic                   wr_c, rd_c, wr_ctrl_c, wr_status_c;
  logic                   any_found_c, all_done_c;
  logic [CORE_IDXW-1:0]   win_idx_c;
  logic [DATAW-1:0]       win_nonce_c;
  logic [DATAW-1:0]       rdata_c;

  // Bus decode; a simultaneous write suppresses the read
  always_comb begin
    addr_u      = 32'(slave_address);
    wr_c        = slave_chipselect & slave_write;
    rd_c        = slave_chipselect & slave_read & ~slave_write;
    wr_ctrl_c   = wr_c & (addr_u == A_CTRL);
    wr_status_c = wr_c & (addr_u == A_STATUS);
  end

  // Winner select: scan high to low so the lowest index found core is kept
  always_comb begin
    any_found_c = |core_found;
    all_done_c  = &core_done;
    win_idx_c   = '0;
    win_nonce_c = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        win_idx_c   = CORE_IDXW'(i);
        win_nonce_c = core_nonce[i*DATAW +: DATAW];
      end
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (addr_u)
      A_CTRL:   rdata_c = DATAW'({irq_en_q, 2'b00});
      A_STATUS: rdata_c = DATAW'({found_q, done_q, (state_q == ST_RUN)});
      A_NONCE:  rdata_c = nonce_found_q;
      A_CORE:   rdata_c = DATAW'(found_core_q);
      A_BASE:   rdata_c = nonce_base_q;
      A_CYCLES: rdata_c = run_cycles_q;
      default: begin
        for (int unsigned i = 0; i < HDR_WORDS; i++)
          if (addr_u == HDR_BASE + i) rdata_c = hdr_q[i];
        for (int unsigned i = 0; i < TGT_WORDS; i++)
          if (addr_u == TGT_BASE + i) rdata_c = tgt_q[i];
      end
    endcase
  end

  // Next-state and register update logic
  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    abort_d       = 1'b0;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    found_d       = found_q;
    nonce_found_d = nonce_found_q;
    found_core_d  = found_core_q;
    nonce_base_d  = nonce_base_q;
    run_cycles_d  = run_cycles_q;
    readdata_d    = readdata_q;
    hdr_d         = hdr_q;
    tgt_d         = tgt_q;
    irq_d         = irq_en_q & (done_q | found_q);

    if (state_q == ST_RUN && run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;

    // W1C applied before hardware sets below so a coincident set wins
    if (wr_status_c) begin
      if (slave_writedata[1]) done_d  = 1'b0;
      if (slave_writedata[2]) found_d = 1'b0;
    end
    if (wr_ctrl_c) irq_en_d = slave_writedata[2];

    // Job configuration is frozen while the cores are running
    if (wr_c && state_q != ST_RUN) begin
      if (addr_u == A_BASE) nonce_base_d = slave_writedata;
      for (int unsigned i = 0; i < HDR_WORDS; i++)
        if (addr_u == HDR_BASE + i) hdr_d[i] = slave_writedata;
      for (int unsigned i = 0; i < TGT_WORDS; i++)
        if (addr_u == TGT_BASE + i) tgt_d[i] = slave_writedata;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_ctrl_c && slave_writedata[0]) begin
          state_d       = ST_RUN;
          start_d       = 1'b1;
          done_d        = 1'b0;
          found_d       = 1'b0;
          nonce_found_d = '0;
          found_core_d  = '0;
          run_cycles_d  = '0;
        end
      end
      ST_RUN: begin
        if (wr_ctrl_c && slave_writedata[1]) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (any_found_c || all_done_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (any_found_c) begin
            found_d       = 1'b1;
            nonce_found_d = win_nonce_c;
            found_core_d  = win_idx_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_c) readdata_d = rdata_c;
  end

  // State and register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      irq_q         <= 1'b0;
      nonce_found_q <= '0;
      found_core_q  <= '0;
      nonce_base_q  <= '0;
      run_cycles_q  <= '0;
      readdata_q    <= '0;
      for (int unsigned i = 0; i < HDR_WORDS; i++) hdr_q[i] <= '0;
      for (int unsigned i = 0; i < TGT_WORDS; i++) tgt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      abort_q       <= abort_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      found_q       <= found_d;
      irq_q         <= irq_d;
      nonce_found_q <= nonce_found_d;
      found_core_q  <= found_core_d;
      nonce_base_q  <= nonce_base_d;
      run_cycles_q  <= run_cycles_d;
      readdata_q    <= readdata_d;
      hdr_q         <= hdr_d;
      tgt_q         <= tgt_d;
    end
  end

  // Output wiring from registers
  always_comb begin
    slave_readdata  = readdata_q;
    irq             = irq_q;
    core_start      = start_q;
    core_abort      = abort_q;
    core_nonce_base = nonce_base_q;
    for (int unsigned i = 0; i < HDR_WORDS; i++) core_header[i*DATAW +: DATAW] = hdr_q[i];
    for (int unsigned i = 0; i < TGT_WORDS; i++) core_target[i*DATAW +: DATAW] = tgt_q[i];
  end

endmodule

// File: tb/tb_miner_csr_array.sv
// Testbench for miner_csr_array: directed scenarios plus randomized bus/core traffic
// checked against a behavioural register model; read data goes through a scoreboard queue.
module tb_miner_csr_array;

  localparam int NC = 4;
  localparam int HW = 19;
  localparam int TW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [5:0]        slave_address;
  logic [31:0]       slave_writedata;
  logic              slave_write, slave_read, slave_chipselect;
  logic [31:0]       slave_readdata;
  logic              irq, core_start, core_abort;
  logic [HW*32-1:0]  core_header;
  logic [TW*32-1:0]  core_target;
  logic [31:0]       core_nonce_base;
  logic [NC-1:0]     core_done, core_found;
  logic [NC*32-1:0]  core_nonce;

  miner_csr_array dut (
    .clk(clk), .reset_n(reset_n),
    .slave_address(slave_address), .slave_writedata(slave_writedata),
    .slave_write(slave_write), .slave_read(slave_read), .slave_chipselect(slave_chipselect),
    .slave_readdata(slave_readdata), .irq(irq),
    .core_start(core_start), .core_abort(core_abort),
    .core_header(core_header), .core_target(core_target), .core_nonce_base(core_nonce_base),
    .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected read data
  logic [31:0] exp_q [$];
  logic [5:0]  rda_q [$];
  logic [31:0] mon_e;
  logic [5:0]  mon_a;

  // Behavioural model of the register file and job state
  bit          m_run, m_irq_en, m_done, m_found;
  logic [31:0] m_nonce, m_base, m_cycles;
  logic [3:0]  m_core;
  logic [31:0] m_hdr [HW];
  logic [31:0] m_tgt [TW];
  bit          e_start, e_abort;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_irq_en = 0; m_done = 0; m_found = 0;
    m_nonce = 0; m_base = 0; m_cycles = 0; m_core = 0;
    e_start = 0; e_abort = 0;
    for (int i = 0; i < HW; i++) m_hdr[i] = 0;
    for (int i = 0; i < TW; i++) m_tgt[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {29'd0, m_irq_en, 2'b00};
    if (ai == 1) return {29'd0, m_found, m_done, m_run};
    if (ai == 2) return m_nonce;
    if (ai == 3) return {28'd0, m_core};
    if (ai == 4) return m_base;
    if (ai == 5) return m_cycles;
    if (ai >= 32 && ai < 32 + HW) return m_hdr[ai-32];
    if (ai >= 56 && ai < 56 + TW) return m_tgt[ai-56];
    return 32'd0;
  endfunction

  // Apply the effect of the inputs present at the clock edge just taken
  task automatic model_update();
    bit w, was_run;
    int ai;
    logic [31:0] d;
    w = slave_chipselect && slave_write;
    ai = int'(slave_address);
    d = slave_writedata;
    was_run = m_run;
    e_start = 0; e_abort = 0;
    if (was_run && m_cycles != 32'hFFFF_FFFF) m_cycles++;
    if (w && ai == 1) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_found = 0;
    end
    if (w && ai == 0) m_irq_en = d[2];
    if (w && !was_run) begin
      if (ai == 4) m_base = d;
      if (ai >= 32 && ai < 32 + HW) m_hdr[ai-32] = d;
      if (ai >= 56 && ai < 56 + TW) m_tgt[ai-56] = d;
    end
    if (!was_run) begin
      if (w && ai == 0 && d[0]) begin
        m_run = 1; e_start = 1;
        m_done = 0; m_found = 0; m_nonce = 0; m_core = 0; m_cycles = 0;
      end
    end else if (w && ai == 0 && d[1]) begin
      m_run = 0; e_abort = 1;
    end else if (core_found != 0 || core_done == '1) begin
      m_run = 0; m_done = 1;
      if (core_found != 0) begin
        m_found = 1;
        for (int i = 0; i < NC; i++) begin
          if (core_found[i]) begin
            m_nonce = core_nonce[i*32 +: 32];
            m_core = 4'(i);
            break;
          end
        end
      end
    end
  endtask

  // One clock: update the model and check every core-facing output against it
  task automatic tick();
    logic exp_irq;
    logic [HW*32-1:0] eh;
    logic [TW*32-1:0] et;
    exp_irq = m_irq_en & (m_done | m_found);
    @(posedge clk);
    #1;
    model_update();
    for (int i = 0; i < HW; i++) eh[i*32 +: 32] = m_hdr[i];
    for (int i = 0; i < TW; i++) et[i*32 +: 32] = m_tgt[i];
    chk("core_start", core_start, e_start);
    chk("core_abort", core_abort, e_abort);
    chk("irq", irq, exp_irq);
    chk("core_header", core_header, eh);
    chk("core_target", core_target, et);
    chk("core_nonce_base", core_nonce_base, m_base);
  endtask

  task automatic drive(input bit w, input bit r, input logic [5:0] a, input logic [31:0] d);
    slave_chipselect = w | r;
    slave_write = w;
    slave_read = r;
    slave_address = a;
    slave_writedata = d;
    if (r && !w) begin
      exp_q.push_back(m_read(a));
      rda_q.push_back(a);
    end
    tick();
    slave_chipselect = 0; slave_write = 0; slave_read = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    drive(1, 0, a, d);
  endtask

  // Read with an independently stated expected value
  task automatic rd_exp(input logic [5:0] a, input logic [31:0] e);
    slave_chipselect = 1; slave_read = 1; slave_write = 0; slave_address = a;
    exp_q.push_back(e);
    rda_q.push_back(a);
    tick();
    slave_chipselect = 0; slave_read = 0;
  endtask

  // Monitor: every accepted read presents data one cycle later
  always @(posedge clk) begin
    if (reset_n && slave_chipselect && slave_read && !slave_write) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_underflow no expected value queued");
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = rda_q.pop_front();
        checks++;
        if (slave_readdata !== mon_e) begin
          errors++;
          $display("FAIL readdata addr=%0h got=%0h exp=%0h", mon_a, slave_readdata, mon_e);
        end
      end
    end
  end

  initial begin
    reset_n = 0;
    slave_address = 0; slave_writedata = 0;
    slave_write = 0; slave_read = 0; slave_chipselect = 0;
    core_done = 0; core_found = 0; core_nonce = 0;
    model_reset();
    #2;
    chk("rst_readdata", slave_readdata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_start", core_start, 0);
    chk("rst_header", core_header, 0);
    #21 reset_n = 1;

    // Header load and start
    for (int i = 0; i < HW; i++) wr(6'(32 + i), 32'(i));
    wr(6'd4, 32'h100);
    wr(6'd0, 32'h1);
    chk("start_pulse", core_start, 1);
    chk("hdr_word5", core_header[5*32 +: 32], 32'd5);
    chk("nonce_base", core_nonce_base, 32'h100);
    rd_exp(6'd1, 32'h1);
    chk("start_one_cycle", core_start, 0);

    // Cores 1 and 3 find together; lowest index wins
    core_nonce = {32'hBB, 32'hCC, 32'hAA, 32'hDD};
    core_found = 4'b1010;
    tick();
    core_found = 4'b0000;
    rd_exp(6'd2, 32'hAA);
    rd_exp(6'd3, 32'h1);
    rd_exp(6'd1, 32'h6);
    core_nonce[31:0] = 32'h55;
    core_found = 4'b0001;
    tick();
    core_found = 0;
    rd_exp(6'd2, 32'hAA);
    rd_exp(6'd3, 32'h1);

    // Exhaustion after 50 RUN cycles without a find
    wr(6'd0, 32'h1);
    for (int i = 0; i < 49; i++) tick();
    core_done = 4'hF;
    tick();
    core_done = 0;
    rd_exp(6'd1, 32'h2);
    rd_exp(6'd5, 32'd50);
    wr(6'd0, 32'h4);
    chk("irq_before", irq, 0);
    tick();
    chk("irq_rise", irq, 1);

    // Partial W1C keeps irq asserted until found is cleared
    wr(6'd0, 32'h5);
    core_found = 4'b0100;
    tick();
    core_found = 0;
    rd_exp(6'd1, 32'h6);
    wr(6'd1, 32'h2);
    rd_exp(6'd1, 32'h4);
    chk("irq_hold", irq, 1);
    wr(6'd1, 32'h4);
    tick();
    chk("irq_drop", irq, 0);

    // Writes during RUN are ignored; start+abort aborts
    wr(6'd0, 32'h1);
    wr(6'd32, 32'hDEAD);
    wr(6'd0, 32'h3);
    chk("abort_pulse", core_abort, 1);
    chk("hdr_frozen", core_header[31:0], 32'h0);
    rd_exp(6'd1, 32'h0);
    chk("abort_one_cycle", core_abort, 0);
    wr(6'd0, 32'h2);
    chk("abort_idle_noop", core_abort, 0);

    // Asynchronous reset in the middle of a run
    wr(6'd0, 32'h1);
    tick(); tick();
    #3 reset_n = 0;
    #1;
    chk("arst_readdata", slave_readdata, 0);
    chk("arst_irq", irq, 0);
    chk("arst_abort", core_abort, 0);
    chk("arst_header", core_header, 0);
    chk("arst_base", core_nonce_base, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1;
    rd_exp(6'd1, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [5:0] a;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      d = $urandom;
      core_nonce = {$urandom, $urandom, $urandom, $urandom};
      core_found = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'd0;
      core_done = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if (r < 30) drive(1, 0, a, d);
      else if (r < 70) drive(0, 1, a, d);
      else if (r < 74) drive(1, 1, a, d);
      else tick();
    end
    core_found = 0; core_done = 0;
    tick(); tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
